// File: rtl/chirp_spi_pkg.sv
// Shared definitions for the chirp SPI scheduler: widths, FSM encoding and
// the transfer-length legality check.
package chirp_spi_pkg;

    localparam int DATA_W  = 32;
    localparam int NBITS_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    // A transfer must move at least one bit and no more than one data word.
    function automatic logic nbits_valid(input logic [NBITS_W-1:0] nb);
        return (nb != '0) && (nb <= NBITS_W'(DATA_W));
    endfunction

endpackage

// File: rtl/chirp_spi_sched_if.sv
// Bundle of requester, configuration, SPI-core and status signals around the
// scheduler. The scheduler uses the slave view; the environment drives master.
interface chirp_spi_sched_if;
    import chirp_spi_pkg::*;

    logic               req0_valid;
    logic               req0_device;
    logic [NBITS_W-1:0] req0_num_bits;
    logic [DATA_W-1:0]  req0_data;
    logic               req0_ready;
    logic               req0_done;

    logic               req1_valid;
    logic               req1_device;
    logic [NBITS_W-1:0] req1_num_bits;
    logic [DATA_W-1:0]  req1_data;
    logic               req1_ready;
    logic               req1_done;

    logic [DATA_W-1:0]  cfg_divider;

    logic               spi_start;
    logic               spi_device;
    logic [NBITS_W-1:0] spi_num_bits;
    logic [DATA_W-1:0]  spi_data;
    logic [DATA_W-1:0]  spi_divider;
    logic               spi_ready;

    logic               busy;
    logic               err_timeout;
    logic               err_param;

    modport slave (
        input  req0_valid, req0_device, req0_num_bits, req0_data,
        input  req1_valid, req1_device, req1_num_bits, req1_data,
        input  cfg_divider, spi_ready,
        output req0_ready, req0_done, req1_ready, req1_done,
        output spi_start, spi_device, spi_num_bits, spi_data, spi_divider,
        output busy, err_timeout, err_param
    );

    modport master (
        output req0_valid, req0_device, req0_num_bits, req0_data,
        output req1_valid, req1_device, req1_num_bits, req1_data,
        output cfg_divider, spi_ready,
        input  req0_ready, req0_done, req1_ready, req1_done,
        input  spi_start, spi_device, spi_num_bits, spi_data, spi_divider,
        input  busy, err_timeout, err_param
    );

endinterface

// File: rtl/chirp_spi_rr_arb.sv
// Two-way round-robin arbiter. On a tie the favoured requester wins; after
// every accepted grant the favour moves to the other requester.
module chirp_spi_rr_arb (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic advance_i,
    output logic grant_o
);

    logic prio_q;
    logic prio_d;

    // Next favoured requester: the one that did not just win.
    always_comb begin
        prio_d = prio_q;
        if (advance_i) begin
            prio_d = ~grant_o;
        end
    end

    // Favour pointer, starting with requester 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Grant index: a lone requester always wins, ties go to the favoured one.
    always_comb begin
        grant_o = 1'b0;
        if (valid0_i && valid1_i) begin
            grant_o = prio_q;
        end else if (valid1_i) begin
            grant_o = 1'b1;
        end
    end

endmodule

// File: rtl/chirp_spi_sched.sv
// Scheduler sharing one SPI core between the host and the sweep engine.
// Grants one command at a time, launches it, waits for completion or timeout,
// then enforces an idle gap before the next grant.
module chirp_spi_sched
    import chirp_spi_pkg::*;
#(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk_i,
    input  logic             rst_i,
    chirp_spi_sched_if.slave bus
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    // Requester views as arrays so both sides share the same logic.
    logic [1:0]         valid_w;
    logic [1:0]         dev_w;
    logic [NBITS_W-1:0] nbits_w [2];
    logic [DATA_W-1:0]  data_w  [2];
    logic [1:0]         ready_w;

    assign valid_w    = {bus.req1_valid, bus.req0_valid};
    assign dev_w      = {bus.req1_device, bus.req0_device};
    assign nbits_w[0] = bus.req0_num_bits;
    assign nbits_w[1] = bus.req1_num_bits;
    assign data_w[0]  = bus.req0_data;
    assign data_w[1]  = bus.req1_data;

    state_t             state_q;
    logic               owner_q;
    logic               spi_start_q;
    logic               spi_device_q;
    logic [NBITS_W-1:0] spi_num_bits_q;
    logic [DATA_W-1:0]  spi_data_q;
    logic [DATA_W-1:0]  spi_divider_q;
    logic [1:0]         done_q;
    logic               err_timeout_q;
    logic               err_param_q;
    logic [15:0]        tmo_cnt_q;
    logic [15:0]        gap_cnt_q;

    logic grant_w;
    logic accept_w;

    assign accept_w = (state_q == ST_IDLE) && (|valid_w);

    chirp_spi_rr_arb u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid0_i (valid_w[0]),
        .valid1_i (valid_w[1]),
        .advance_i(accept_w),
        .grant_o  (grant_w)
    );

    // Acceptance is combinational so the requester sees it in the grant cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_w[gi] = accept_w && (grant_w == 1'(gi));
        end
    endgenerate

    // Scheduler FSM: grant/latch, one-cycle start, completion wait, gap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            spi_start_q    <= 1'b0;
            spi_device_q   <= 1'b0;
            spi_num_bits_q <= '0;
            spi_data_q     <= '0;
            spi_divider_q  <= '0;
            done_q         <= '0;
            err_timeout_q  <= 1'b0;
            err_param_q    <= 1'b0;
            tmo_cnt_q      <= '0;
            gap_cnt_q      <= '0;
        end else begin
            spi_start_q <= 1'b0;
            done_q      <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_w) begin
                        owner_q        <= grant_w;
                        spi_device_q   <= dev_w[grant_w];
                        spi_num_bits_q <= nbits_w[grant_w];
                        spi_data_q     <= data_w[grant_w];
                        spi_divider_q  <= bus.cfg_divider;
                        if (nbits_valid(nbits_w[grant_w])) begin
                            spi_start_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end else begin
                            // Illegal length: report and finish without touching the core.
                            err_param_q      <= 1'b1;
                            done_q[grant_w]  <= 1'b1;
                            gap_cnt_q        <= '0;
                            state_q          <= ST_GAP;
                        end
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt_q <= '0;
                    state_q   <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // Completion takes precedence over a coinciding timeout.
                    if (bus.spi_ready) begin
                        done_q[owner_q] <= 1'b1;
                        gap_cnt_q       <= '0;
                        state_q         <= ST_GAP;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        err_timeout_q   <= 1'b1;
                        done_q[owner_q] <= 1'b1;
                        gap_cnt_q       <= '0;
                        state_q         <= ST_GAP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready   = ready_w[0];
    assign bus.req1_ready   = ready_w[1];
    assign bus.req0_done    = done_q[0];
    assign bus.req1_done    = done_q[1];
    assign bus.spi_start    = spi_start_q;
    assign bus.spi_device   = spi_device_q;
    assign bus.spi_num_bits = spi_num_bits_q;
    assign bus.spi_data     = spi_data_q;
    assign bus.spi_divider  = spi_divider_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.err_timeout  = err_timeout_q;
    assign bus.err_param    = err_param_q;

endmodule

// File: tb/tb_chirp_spi_sched.sv
// Randomized bench for chirp_spi_sched against a transaction-level model:
// the model predicts the winner, the latched fields, when done fires, the
// error flags and how long busy stays high.
module tb_chirp_spi_sched;

    localparam int GAP = 4;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    chirp_spi_sched_if bus();

    chirp_spi_sched #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_prio      = 0;
    bit m_err_param = 1'b0;
    bit m_err_tmo   = 1'b0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_quiet();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.spi_ready  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        expect_eq({tag, "_start"},  32'(bus.spi_start), 0);
        expect_eq({tag, "_ready"},  32'({bus.req1_ready, bus.req0_ready}), 0);
        expect_eq({tag, "_done"},   32'({bus.req1_done, bus.req0_done}), 0);
        expect_eq({tag, "_busy"},   32'(bus.busy), 0);
        expect_eq({tag, "_errs"},   32'({bus.err_timeout, bus.err_param}), 0);
        expect_eq({tag, "_dev"},    32'(bus.spi_device), 0);
        expect_eq({tag, "_nbits"},  32'(bus.spi_num_bits), 0);
        expect_eq({tag, "_data"},   bus.spi_data, 0);
        expect_eq({tag, "_div"},    bus.spi_divider, 0);
    endtask

    // One complete command. resp = WAIT_DONE cycle index on which the core
    // answers; resp > TMO means it never answers.
    task automatic run_txn(input bit v0, input bit v1, input bit dv0, input bit dv1,
                           input logic [5:0] nb0, input logic [5:0] nb1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] div, input int resp);
        int g;
        int stop;
        bit bad;
        logic        e_dev;
        logic [5:0]  e_nb;
        logic [31:0] e_dat;

        @(negedge clk);
        expect_eq("idle_busy", 32'(bus.busy), 0);
        bus.req0_valid = v0;  bus.req0_device = dv0; bus.req0_num_bits = nb0; bus.req0_data = d0;
        bus.req1_valid = v1;  bus.req1_device = dv1; bus.req1_num_bits = nb1; bus.req1_data = d1;
        bus.cfg_divider = div;
        #1;
        g = (v0 && v1) ? m_prio : (v1 ? 1 : 0);
        expect_eq("grant_ready0", 32'(bus.req0_ready), 32'(g == 0));
        expect_eq("grant_ready1", 32'(bus.req1_ready), 32'(g == 1));
        m_prio = 1 - g;
        e_dev = g ? dv1 : dv0;
        e_nb  = g ? nb1 : nb0;
        e_dat = g ? d1  : d0;
        bad   = (e_nb == 6'd0) || (e_nb > 6'd32);
        if (bad) m_err_param = 1'b1;
        $display("txn: v0=%0b v1=%0b grant=%0d nbits=%0d data=0x%08h resp=%0d", v0, v1, g, e_nb, e_dat, resp);

        // Cycle after grant: requests still held, must not be accepted again.
        @(negedge clk);
        expect_eq("hold_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
        drive_quiet();
        bus.req0_data   = $urandom;
        bus.req1_data   = $urandom;
        bus.cfg_divider = $urandom;
        expect_eq("lat_dev",   32'(bus.spi_device), 32'(e_dev));
        expect_eq("lat_nbits", 32'(bus.spi_num_bits), 32'(e_nb));
        expect_eq("lat_data",  bus.spi_data, e_dat);
        expect_eq("lat_div",   bus.spi_divider, div);
        expect_eq("busy_1",    32'(bus.busy), 1);

        if (bad) begin
            expect_eq("bad_nostart", 32'(bus.spi_start), 0);
            expect_eq("bad_done",    32'({bus.req1_done, bus.req0_done}), 32'(g ? 2 : 1));
            expect_eq("bad_errp",    32'(bus.err_param), 1);
        end else begin
            expect_eq("start_pulse", 32'(bus.spi_start), 1);
            expect_eq("start_nodone", 32'({bus.req1_done, bus.req0_done}), 0);
            stop = (resp < TMO) ? resp : TMO;
            for (int k = 0; k <= stop; k++) begin
                @(negedge clk);
                expect_eq("wait_nostart", 32'(bus.spi_start), 0);
                expect_eq("wait_nodone",  32'({bus.req1_done, bus.req0_done}), 0);
                bus.req0_valid = 1'($urandom_range(0, 1));
                bus.req1_valid = 1'($urandom_range(0, 1));
                bus.spi_ready  = (k == resp);
                #1;
                expect_eq("wait_noready", 32'({bus.req1_ready, bus.req0_ready}), 0);
            end
            if (resp > TMO) m_err_tmo = 1'b1;
            @(negedge clk);
            drive_quiet();
            expect_eq("fin_done", 32'({bus.req1_done, bus.req0_done}), 32'(g ? 2 : 1));
            expect_eq("fin_errt", 32'(bus.err_timeout), 32'(m_err_tmo));
            expect_eq("fin_data", bus.spi_data, e_dat);
        end

        // Remaining gap cycles; stray core completions must be ignored.
        for (int i = 2; i <= GAP; i++) begin
            @(negedge clk);
            expect_eq("gap_busy", 32'(bus.busy), 1);
            expect_eq("gap_nodone", 32'({bus.req1_done, bus.req0_done}), 0);
            bus.spi_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.spi_ready = 1'b0;
        expect_eq("end_idle",   32'(bus.busy), 0);
        expect_eq("end_nodone", 32'({bus.req1_done, bus.req0_done}), 0);
        expect_eq("end_errp",   32'(bus.err_param), 32'(m_err_param));
        expect_eq("end_errt",   32'(bus.err_timeout), 32'(m_err_tmo));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_quiet();
        bus.req0_device = 1'b0; bus.req0_num_bits = '0; bus.req0_data = '0;
        bus.req1_device = 1'b0; bus.req1_num_bits = '0; bus.req1_data = '0;
        bus.cfg_divider = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;

        // Simultaneous requests: grants alternate 0,1,0.
        repeat (3) run_txn(1, 1, 0, 1, 6'd8, 6'd16, $urandom, $urandom, 32'd3, 3);

        // Host alone, 24 bits to device 1, immediate completion.
        run_txn(1, 0, 1, 0, 6'd24, 6'd5, 32'hABCDEF00, 32'h0, 32'd7, 0);

        // Illegal lengths.
        run_txn(1, 0, 0, 0, 6'd0, 6'd8, 32'h11, 32'h22, 32'd2, 0);
        run_txn(0, 1, 0, 1, 6'd8, 6'd33, 32'h33, 32'h44, 32'd2, 0);

        // Core never answers, then answer on the timeout cycle itself.
        run_txn(0, 1, 0, 0, 6'd8, 6'd20, 32'h55, 32'h66, 32'd9, TMO + 5);
        run_txn(1, 0, 1, 0, 6'd32, 6'd20, 32'h77, 32'h88, 32'd9, TMO);

        // Reset while waiting on the core.
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_num_bits = 6'd12; bus.req0_data = 32'hCAFE0001;
        bus.cfg_divider = 32'd5;
        @(negedge clk);
        drive_quiet();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        m_prio = 0; m_err_param = 1'b0; m_err_tmo = 1'b0;
        repeat (3) begin
            @(negedge clk);
            expect_eq("midrst_nodone", 32'({bus.req1_done, bus.req0_done}), 0);
            expect_eq("midrst_idle", 32'(bus.busy), 0);
        end
        run_txn(1, 1, 1, 0, 6'd10, 6'd11, 32'h12345678, 32'h9ABCDEF0, 32'd4, 2);

        // Random traffic.
        repeat (40) begin
            int sel;
            int r;
            int resp;
            sel  = $urandom_range(1, 3);
            r    = $urandom_range(0, 9);
            resp = (r == 0) ? TMO + 1 : $urandom_range(0, 15);
            run_txn(sel[0], sel[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    6'($urandom_range(0, 40)), 6'($urandom_range(0, 40)),
                    $urandom, $urandom, $urandom, resp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chirp_spi_sched.md
CHIRP_SPI_SCHED -- requirements
Module: chirp_spi_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 4: idle clocks inserted between consecutive SPI transactions.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: clocks to wait for core completion before abort.
REQ-003 clock  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester 0 (host) / requester 1 (sweep engine) has a command.
REQ-006 reqN_device  input  1  target chip select for requester N (0 or 1).
REQ-007 reqN_num_bits  input  6  transfer length in bits for requester N.
REQ-008 reqN_data  input  32  MSB-first payload for requester N.
REQ-009 reqN_ready  output  1  one-cycle pulse; command of requester N accepted this cycle.
REQ-010 reqN_done  output  1  one-cycle pulse; requester N's command finished (success or error).
REQ-011 cfg_divider  input  32  SCLK divider; sampled at grant.
REQ-012 spi_start  output  1  start pulse to the SPI core.
REQ-013 spi_device, spi_num_bits, spi_data, spi_divider  output  1/6/32/32  latched command fields to the SPI core.
REQ-014 spi_ready  input  1  one-cycle completion pulse from the SPI core.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 err_timeout, err_param  output  1  sticky error flags, cleared only by reset.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE and GAP.
REQ-018 In IDLE with one valid request, that requester SHALL be granted; with both valid, the requester not granted last SHALL win (round-robin); after reset, requester 0 SHALL win first.
REQ-019 In the grant cycle, reqN_ready SHALL be asserted combinationally, and all reqN fields plus cfg_divider SHALL be latched into the spi_* registers at that clock edge.
REQ-020 If the latched num_bits is 0 or greater than 32, err_param SHALL set, reqN_done SHALL pulse one cycle after grant, no spi_start SHALL issue, and the FSM SHALL enter GAP.
REQ-021 Otherwise the FSM SHALL enter ISSUE, where spi_start is high for exactly one cycle, then enter WAIT_DONE.
REQ-022 In WAIT_DONE, a 16-bit timeout counter SHALL start at 0 and increment each cycle.
REQ-023 A spi_ready pulse in WAIT_DONE SHALL pulse the granted reqN_done in the next cycle and move the FSM to GAP.
REQ-024 When the counter reaches TIMEOUT_CYCLES with no spi_ready, err_timeout SHALL set, reqN_done SHALL pulse, and the FSM SHALL move to GAP.
REQ-025 If spi_ready and timeout coincide, the transaction SHALL count as success, with no error set.
REQ-026 GAP SHALL last exactly GAP_CYCLES clocks (one clock if GAP_CYCLES=0), then return to IDLE.
REQ-027 spi_ready outside WAIT_DONE SHALL be ignored.
REQ-028 spi_* fields SHALL stay stable from grant until the next grant.
REQ-029 Requests SHALL NOT be accepted outside IDLE; reqN_ready SHALL stay low.
REQ-030 Back-to-back latency SHALL be: grant (IDLE) -> spi_start one cycle later.

Reset
REQ-031 On reset, the FSM SHALL enter IDLE.
REQ-032 On reset, spi_start, reqN_ready, reqN_done, busy, err_timeout and err_param SHALL be 0.
REQ-033 On reset, spi_* data registers SHALL be 0, the round-robin pointer SHALL favour requester 0, and all counters SHALL be 0.
REQ-034 Reset asserted mid-transaction SHALL abort it with no done pulse.

Structure
REQ-035 A shared package chirp_spi_pkg SHALL hold the FSM state encoding, the data width (32) and the num_bits width (6).
REQ-036 The two-way round-robin arbiter SHALL be a sub-module chirp_spi_rr_arb (inputs: two valids, advance strobe; output: grant index).

Verification
REQ-037 The bench SHALL cover: req0 alone, num_bits=24, data=0xABCDEF00, device=1 -> req0_ready, spi_start one cycle later, spi_data=0xABCDEF00; spi_ready -> req0_done next cycle; busy low after GAP_CYCLES.
REQ-038 The bench SHALL cover: req0 and req1 valid together, three times -> grants ordered 0,1,0, each separated by GAP.
REQ-039 The bench SHALL cover: num_bits=0, then num_bits=33 -> no spi_start, err_param=1, reqN_done pulses.
REQ-040 The bench SHALL cover: spi_ready never returned, TIMEOUT_CYCLES=100 -> err_timeout at cycle 100 of WAIT_DONE, req done pulse, FSM recovers to IDLE.
REQ-041 The bench SHALL cover: spi_ready on the same cycle as timeout -> success, err_timeout stays 0.
REQ-042 The bench SHALL cover: reset asserted in WAIT_DONE -> all outputs 0 next cycle, no done pulse; a later request is accepted normally.
